// File: rtl/seq_shift_add_mul.sv
// Iterative radix-2 shift-add multiplier: WIDTH cycles per product, valid/ready on both sides.
// Signed mode multiplies magnitudes and applies the sign once at the end.
module seq_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH:0]       psum;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 last;

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // Partial sum keeps its carry; the shift folds it back into the accumulator top bit
  assign psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
  assign acc_step = {psum, acc[WIDTH-1:1]};
  assign last     = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = CALC;
      end
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      z      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= a_mag;
          mplier <= b_mag;
          neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) z <= neg ? -acc_step : acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Bench for seq_shift_add_mul (WIDTH=8): vector table, backpressure, mid-op reset, back-to-back stream.
module tb_seq_shift_add_mul;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] z;
  logic           busy;

  int nchk = 0;
  int nerr = 0;
  logic [2*W-1:0] sb[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] z;
  } vec_t;
  vec_t vecs[8];

  seq_shift_add_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    logic signed [2*W-1:0] sx, sy;
    if (s) begin
      sx = {{W{x[W-1]}}, x};
      sy = {{W{y[W-1]}}, y};
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  task automatic pop_chk(input string nm);
    logic [2*W-1:0] e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk(nm, 32'(z), 32'(e));
    end
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                        input logic [2*W-1:0] exp, input string nm);
    int lat;
    a = xa; b = xb; is_signed = xs; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
    chk({nm, "_latency"}, 32'(lat), 32'(W));
    pop_chk({nm, "_z"});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_ov_drop"}, 32'(out_valid), 32'd0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen, lat, acc_n, hs_n, last_hs, cyc;
    logic acc_s, hs_s;

    vecs[0] = '{8'd13, 8'd11, 1'b0, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[2] = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
    vecs[3] = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[5] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vecs[6] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[7] = '{8'h00, 8'h7F, 1'b1, 16'h0000};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_z", 32'(z), 32'd0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].z, $sformatf("vec%0d", i));

    // Backpressure: product must hold while consumer stalls and new operands wait
    a = 8'h12; b = 8'h34; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h77; b = 8'h99;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
    chk("bp_latency", 32'(lat), 32'(W));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ov%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ir%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_z%0d", i), 32'(z), 32'h03A8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ov_drop", 32'(out_valid), 32'd0);
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("bp_no_extra_op", 32'(seen), 32'd0);

    // Reset on the fourth CALC cycle discards the operation
    a = 8'h55; b = 8'h33; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_z", 32'(z), 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_product", 32'(seen), 32'd0);
    run_op(8'd6, 8'd7, 1'b0, 16'd42, "after_rst");

    // Back-to-back stream with both handshakes held high
    a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    acc_n = 0; hs_n = 0; last_hs = -1; cyc = 0;
    while (hs_n < 200 && cyc < 3000) begin
      acc_s = in_valid && in_ready;
      hs_s  = out_valid && out_ready;
      if (hs_s) begin
        pop_chk($sformatf("b2b_z%0d", hs_n));
        if (hs_n > 0) chk($sformatf("b2b_gap%0d", hs_n), 32'(cyc - last_hs), 32'(W + 2));
        last_hs = cyc;
        hs_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_s) begin
        sb.push_back(ref_mul(a, b, is_signed));
        acc_n++;
        a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
      end
      if (hs_n == 200) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_count", 32'(hs_n), 32'd200);
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
